// File: rtl/jtag_link_sched.sv
// JTAG UART link scheduler: config byte reception and acked sample upload.
// Define LINK_CHECKSUM_EN to append an acked checksum frame after the last sample.
module jtag_link_sched #(
  parameter int N_SAMPLES   = 128,
  parameter int ACK_TIMEOUT = 50000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  input  logic        start_upload,
  output logic [23:0] cfg_word,
  output logic        cfg_valid,
  output logic [7:0]  smp_addr,
  input  logic [9:0]  smp_data,
  output logic        upload_busy,
  output logic        upload_done,
  output logic        link_err
);
  typedef enum logic [3:0] {
    RX_CFG, IDLE, FETCH, TX_LO, TX_HI, WAIT_ACK, DONE
`ifdef LINK_CHECKSUM_EN
    , CK_LO, CK_HI
`endif
  } state_t;

  localparam logic [31:0] T_MAX = 32'(ACK_TIMEOUT - 1);
  localparam logic [7:0] IDX_LAST = 8'(N_SAMPLES - 1);
  localparam logic [7:0] R_MAX = 8'(MAX_RETRY);

  state_t state, state_n;
  logic [1:0] k;
  logic [17:0] shadow;
  logic [7:0] idx, retry, wbyte, wbyte_n;
  logic [9:0] frame;
  logic [31:0] timer;
  logic fetch_ph;
  logic rd_done, wr_done, bus_idle, rx_ok, is_ack;
  logic cfg_hit, expired, last, want_rd, want_wr;
  logic unused_rd;
`ifdef LINK_CHECKSUM_EN
  logic [9:0] sum;
  logic ck_ph;
`endif

  assign bus_idle = !av_read && !av_write;
  assign rd_done = av_read && !av_waitrequest;
  assign wr_done = av_write && !av_waitrequest;
  assign rx_ok = rd_done && av_readdata[15];
  assign is_ack = rx_ok && av_readdata[7:6] == 2'b10;
  assign cfg_hit = rx_ok && av_readdata[7:6] == {~k[0], k[0]};
  // a held read must finish before a timeout can act
  assign expired = timer == T_MAX && (!av_read || rd_done);
  assign last = idx == IDX_LAST;
  assign smp_addr = idx;
  assign upload_done = state == DONE;
  assign av_writedata = {24'd0, wbyte};
  assign unused_rd = ^{av_readdata[31:16], av_readdata[14:8]};

  always_ff @(posedge clk) begin
    if (reset) state <= RX_CFG;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    want_rd = 1'b0;
    want_wr = 1'b0;
    wbyte_n = 8'd0;
    unique case (state)
      RX_CFG: begin
        want_rd = 1'b1;
        if (cfg_hit && k == 2'd3) state_n = IDLE;
      end
      IDLE: if (start_upload) state_n = FETCH;
      FETCH: if (fetch_ph) state_n = TX_LO;
      TX_LO: begin
        want_wr = 1'b1;
        wbyte_n = {3'b000, frame[4:0]};
        if (wr_done) state_n = TX_HI;
      end
      TX_HI: begin
        want_wr = 1'b1;
        wbyte_n = {3'b111, frame[9:5]};
        if (wr_done) state_n = WAIT_ACK;
      end
`ifdef LINK_CHECKSUM_EN
      CK_LO: begin
        want_wr = 1'b1;
        wbyte_n = {3'b010, sum[4:0]};
        if (wr_done) state_n = CK_HI;
      end
      CK_HI: begin
        want_wr = 1'b1;
        wbyte_n = {3'b011, sum[9:5]};
        if (wr_done) state_n = WAIT_ACK;
      end
`endif
      WAIT_ACK: begin
        want_rd = timer != T_MAX;
        if (is_ack) begin
`ifdef LINK_CHECKSUM_EN
          if (ck_ph) state_n = DONE;
          else if (last) state_n = CK_LO;
          else state_n = FETCH;
`else
          state_n = last ? DONE : FETCH;
`endif
        end else if (expired) begin
          if (retry < R_MAX) begin
`ifdef LINK_CHECKSUM_EN
            state_n = ck_ph ? CK_LO : TX_LO;
`else
            state_n = TX_LO;
`endif
          end else begin
            state_n = RX_CFG;
          end
        end
      end
      DONE: state_n = RX_CFG;
      default: state_n = RX_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      av_read <= 1'b0;
      av_write <= 1'b0;
      wbyte <= 8'd0;
      cfg_word <= 24'd0;
      cfg_valid <= 1'b0;
      upload_busy <= 1'b0;
      link_err <= 1'b0;
      k <= 2'd0;
      shadow <= 18'd0;
      idx <= 8'd0;
      retry <= 8'd0;
      frame <= 10'd0;
      timer <= 32'd0;
      fetch_ph <= 1'b0;
`ifdef LINK_CHECKSUM_EN
      sum <= 10'd0;
      ck_ph <= 1'b0;
`endif
    end else begin
      cfg_valid <= 1'b0;
      if (rd_done || wr_done) begin
        av_read <= 1'b0;
        av_write <= 1'b0;
      end else if (bus_idle && want_rd) begin
        av_read <= 1'b1;
      end else if (bus_idle && want_wr) begin
        av_write <= 1'b1;
        wbyte <= wbyte_n;
      end
      if (state == WAIT_ACK && timer != T_MAX) timer <= timer + 32'd1;
      unique case (state)
        RX_CFG: if (cfg_hit) begin
          // earlier fields are staged so a partial config never shows
          if (k == 2'd3) begin
            cfg_word <= {av_readdata[5:0], shadow};
            cfg_valid <= 1'b1;
            link_err <= 1'b0;
            k <= 2'd0;
          end else begin
            shadow <= {av_readdata[5:0], shadow[17:6]};
            k <= k + 2'd1;
          end
        end
        IDLE: if (start_upload) begin
          idx <= 8'd0;
          retry <= 8'd0;
          upload_busy <= 1'b1;
          fetch_ph <= 1'b0;
`ifdef LINK_CHECKSUM_EN
          sum <= 10'd0;
          ck_ph <= 1'b0;
`endif
        end
        FETCH: begin
          fetch_ph <= !fetch_ph;
          if (fetch_ph) begin
            frame <= smp_data;
`ifdef LINK_CHECKSUM_EN
            sum <= sum + smp_data;
`endif
          end
        end
        TX_HI: if (wr_done) timer <= 32'd0;
`ifdef LINK_CHECKSUM_EN
        CK_HI: if (wr_done) timer <= 32'd0;
`endif
        WAIT_ACK: begin
          if (is_ack) begin
            retry <= 8'd0;
`ifdef LINK_CHECKSUM_EN
            if (ck_ph) upload_busy <= 1'b0;
            else if (last) ck_ph <= 1'b1;
            else idx <= idx + 8'd1;
`else
            if (last) upload_busy <= 1'b0;
            else idx <= idx + 8'd1;
`endif
          end else if (expired) begin
            if (retry < R_MAX) begin
              retry <= retry + 8'd1;
            end else begin
              link_err <= 1'b1;
              upload_busy <= 1'b0;
              k <= 2'd0;
            end
          end
        end
        DONE: k <= 2'd0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_link_sched.sv
// Scoreboard bench for jtag_link_sched with a laptop/JTAG UART model.
// Random samples, stray bytes and wait states are checked against spec arithmetic.
module tb_jtag_link_sched;
  localparam int NS = 4;
  localparam int TO = 200;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic reset;
  logic av_read, av_write, av_waitrequest;
  logic [31:0] av_writedata, av_readdata;
  logic start_upload;
  logic [23:0] cfg_word;
  logic cfg_valid;
  logic [7:0] smp_addr;
  logic [9:0] smp_data;
  logic upload_busy, upload_done, link_err;

  int total = 0;
  int bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_wr[$];
  logic [23:0] exp_cfg[$];
  logic [9:0] mem [256];
  bit ack_mode = 1'b1;
  bit hold_mode = 1'b0;
  int wr_in_upload = 0;
  int cfg_pulses = 0;
  int done_pulses = 0;
  bit in_req = 1'b0;
  bit granted = 1'b0;
  bit held = 1'b0;
  int wcnt = 0;
  logic hold_rd, hold_wr;
  logic [31:0] hold_data;
  logic [7:0] b;
  bit act;
  int n;

  always #10 clk = ~clk;

  jtag_link_sched #(.N_SAMPLES(NS), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset),
    .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .start_upload(start_upload),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid),
    .smp_addr(smp_addr), .smp_data(smp_data),
    .upload_busy(upload_busy), .upload_done(upload_done),
    .link_err(link_err)
  );

  always @(posedge clk) smp_data <= mem[smp_addr];

  task automatic check(input string name, input logic [31:0] act_v,
                       input logic [31:0] req_v);
    total++;
    if (act_v !== req_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act_v, req_v);
    end
  endtask

  function automatic logic [7:0] stray(input logic [1:0] avoid);
    logic [1:0] t;
    t = 2'($urandom);
    while (t == avoid) t = 2'($urandom);
    return {t, 6'($urandom)};
  endfunction

  // Avalon slave + laptop model
  always @(negedge clk) begin
    if (reset) begin
      in_req = 1'b0;
      granted = 1'b0;
      held = 1'b0;
      av_waitrequest = 1'b1;
      av_readdata = 32'd0;
    end else begin
      if (granted) check("gap", {30'd0, av_read, av_write}, 32'd0);
      if (held) begin
        check("hold_req", {30'd0, av_read, av_write}, {30'd0, hold_rd, hold_wr});
        if (hold_wr) check("hold_data", av_writedata, hold_data);
      end
      granted = 1'b0;
      held = 1'b0;
      if (av_read || av_write) begin
        check("rw_excl", {31'd0, av_read & av_write}, 32'd0);
        if (!in_req) begin
          in_req = 1'b1;
          wcnt = (hold_mode && av_write && wr_in_upload == 1) ? 5 : $urandom_range(0, 2);
        end
        if (wcnt > 0) begin
          wcnt--;
          av_waitrequest = 1'b1;
          held = 1'b1;
          hold_rd = av_read;
          hold_wr = av_write;
          hold_data = av_writedata;
        end else begin
          av_waitrequest = 1'b0;
          in_req = 1'b0;
          granted = 1'b1;
          if (av_read) begin
            if (rx_q.size() > 0 && $urandom_range(0, 3) != 0)
              av_readdata = {16'd0, 8'h80, rx_q.pop_front()};
            else
              av_readdata = {16'd0, 1'b0, 15'($urandom)};
          end else begin
            b = av_writedata[7:0];
            wr_in_upload++;
            check("wr_upper_zero", {8'd0, av_writedata[31:8]}, 32'd0);
            if (exp_wr.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_write: got %02h want none", b);
            end else begin
              check("wr_byte", {24'd0, b}, {24'd0, exp_wr.pop_front()});
            end
            if (ack_mode && (b[7:5] == 3'b111 || b[7:5] == 3'b011)) begin
              repeat ($urandom_range(0, 2)) rx_q.push_back(stray(2'b10));
              rx_q.push_back(8'h80);
            end
          end
        end
      end else begin
        av_waitrequest = 1'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && cfg_valid) begin
      cfg_pulses++;
      if (exp_cfg.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cfg: got %06h want none", cfg_word);
      end else begin
        check("cfg_word", {8'd0, cfg_word}, {8'd0, exp_cfg.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && upload_done) begin
      done_pulses++;
      check("done_after_last", exp_wr.size(), 32'd0);
    end
  end

  task automatic send_cfg(input logic [23:0] w, input bit strays);
    logic [1:0] tag;
    exp_cfg.push_back(w);
    for (int i = 0; i < 4; i++) begin
      tag = (i % 2 == 0) ? 2'b10 : 2'b01;
      if (strays && $urandom_range(0, 1) == 1) rx_q.push_back(stray(tag));
      rx_q.push_back({tag, w[6*i +: 6]});
    end
  endtask

  task automatic wait_cfg(input int target);
    int c = 0;
    while (cfg_pulses < target && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
    check("cfg_pulses", cfg_pulses, target);
    check("cfg_rx_drained", rx_q.size(), 32'd0);
  endtask

  task automatic run_upload(input bit ack, input bit hold);
    int s;
    int sum;
    int d0;
    int c;
    sum = 0;
    ack_mode = ack;
    hold_mode = hold;
    wr_in_upload = 0;
    d0 = done_pulses;
    if (ack) begin
      for (int i = 0; i < NS; i++) begin
        s = int'(mem[i]);
        exp_wr.push_back(8'(s % 32));
        exp_wr.push_back(8'(224 + s / 32));
        sum += s;
      end
`ifdef LINK_CHECKSUM_EN
      sum = sum % 1024;
      exp_wr.push_back(8'(64 + sum % 32));
      exp_wr.push_back(8'(96 + sum / 32));
`endif
    end else begin
      s = int'(mem[0]);
      for (int r = 0; r <= MR; r++) begin
        exp_wr.push_back(8'(s % 32));
        exp_wr.push_back(8'(224 + s / 32));
      end
    end
    @(negedge clk);
    start_upload = 1'b1;
    @(negedge clk);
    start_upload = 1'b0;
    check("busy_on_start", {31'd0, upload_busy}, 32'd1);
    c = 0;
    while (upload_busy && c < 20000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check("busy_dropped", {31'd0, upload_busy}, 32'd0);
    check("all_writes_seen", exp_wr.size(), 32'd0);
    check("done_count", done_pulses - d0, ack ? 32'd1 : 32'd0);
    check("link_err", {31'd0, link_err}, ack ? 32'd0 : 32'd1);
    ack_mode = 1'b1;
    hold_mode = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_upload = 1'b0;
    av_waitrequest = 1'b1;
    av_readdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 10'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl",
          {26'd0, av_read, av_write, cfg_valid, upload_busy, upload_done, link_err},
          32'd0);
    check("reset_cfg_word", {8'd0, cfg_word}, 32'd0);
    check("reset_bus_data", av_writedata, 32'd0);
    check("reset_smp_addr", {24'd0, smp_addr}, 32'd0);
    reset = 1'b0;

    // partial config cut by reset must not publish
    rx_q.push_back(8'h85);
    rx_q.push_back(8'h4A);
    n = 0;
    while (rx_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_drops_req", {30'd0, av_read, av_write}, 32'd0);
    reset = 1'b0;
    check("no_partial_cfg", {8'd0, cfg_word}, 32'd0);
    check("no_partial_pulse", cfg_pulses, 32'd0);

    send_cfg(24'h01FA85, 1'b0);
    wait_cfg(1);
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (av_read || av_write) act = 1'b1;
    end
    check("idle_quiet", {31'd0, act}, 32'd0);

    mem[0] = 10'h3FF;
    mem[1] = 10'h000;
    mem[2] = 10'h155;
    mem[3] = 10'h2AA;
    run_upload(1'b1, 1'b1);

    // start_upload while receiving config is ignored
    @(negedge clk);
    start_upload = 1'b1;
    @(negedge clk);
    start_upload = 1'b0;
    repeat (20) @(negedge clk);
    check("start_ignored", {31'd0, upload_busy}, 32'd0);

    rx_q.push_back(8'h45);
    send_cfg(24'h01FA85, 1'b0);
    wait_cfg(2);

    mem[0] = 10'($urandom);
    run_upload(1'b0, 1'b0);

    send_cfg(24'($urandom), 1'b1);
    wait_cfg(3);
    check("link_err_cleared", {31'd0, link_err}, 32'd0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NS; i++) mem[i] = 10'($urandom);
      run_upload(1'b1, 1'b0);
      send_cfg(24'($urandom), 1'b1);
      wait_cfg(4 + t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
